// File: rtl/sync_fifo_v2.sv
// Single-clock show-ahead FIFO for any DEPTH >= 2, with occupancy count and almost-full/empty flags.
// Define SYNC_FIFO_V2_ERR_EN to add sticky overflow/underflow flags and the err_clr port.
module sync_fifo_v2 #(
   parameter  int unsigned WIDTH    = 8,
   parameter  int unsigned DEPTH    = 2,
   parameter  int unsigned AF_LEVEL = DEPTH - 1,
   parameter  int unsigned AE_LEVEL = 1,
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ren,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CNT_W-1:0] count
`ifdef SYNC_FIFO_V2_ERR_EN
   ,input  logic            err_clr
   ,output logic            overflow
   ,output logic            underflow
`endif
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic [PTR_W-1:0] w_wr_ptr_nxt;
   logic [PTR_W-1:0] w_rd_ptr_nxt;
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_full;
   logic             w_empty;
   logic             w_wr_acc;
   logic             w_rd_acc;

   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign w_empty  = (r_count == '0);
   // A write into a full FIFO is still taken when the head is popped on the same edge.
   assign w_wr_acc = wen & (~w_full | ren);
   assign w_rd_acc = ren & ~w_empty;

   // Next-state for pointers and occupancy; explicit wrap so non-power-of-2 depths work.
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_count_nxt  = r_count;
      if (w_wr_acc) begin
         w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_acc) begin
         w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
      end
   end

   // Storage is not reset; entries outside [rd_ptr, wr_ptr) are never observed.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   assign data_out     = w_empty ? '0 : r_mem[r_rd_ptr];
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= CNT_W'(AF_LEVEL));
   assign almost_empty = (r_count <= CNT_W'(AE_LEVEL));
   assign count        = r_count;

`ifdef SYNC_FIFO_V2_ERR_EN
   logic r_overflow;
   logic r_underflow;
   logic w_ovf_set;
   logic w_unf_set;

   // A read paired with an accepted write on an empty FIFO is not an underflow.
   assign w_ovf_set = wen & w_full & ~ren;
   assign w_unf_set = ren & w_empty & ~wen;

   // Sticky flags; a new error event takes priority over err_clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (err_clr) begin
            r_overflow <= 1'b0;
         end
         if (w_unf_set) begin
            r_underflow <= 1'b1;
         end else if (err_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed bench for sync_fifo_v2 at WIDTH=8, DEPTH=3, AF_LEVEL=2, AE_LEVEL=1.
module tb_sync_fifo_v2;

   logic       clk;
   logic       rst;
   logic       wen;
   logic [7:0] data_in;
   logic       ren;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [1:0] count;
`ifdef SYNC_FIFO_V2_ERR_EN
   logic       err_clr;
   logic       overflow;
   logic       underflow;
`endif

   int errors;
   int checks;

   sync_fifo_v2 #(.WIDTH(8), .DEPTH(3), .AF_LEVEL(2), .AE_LEVEL(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .wen          (wen),
      .data_in      (data_in),
      .ren          (ren),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count)
`ifdef SYNC_FIFO_V2_ERR_EN
      ,.err_clr     (err_clr)
      ,.overflow    (overflow)
      ,.underflow   (underflow)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wen = 1'b0; ren = 1'b0; data_in = 8'h00;
`ifdef SYNC_FIFO_V2_ERR_EN
      err_clr = 1'b0;
`endif
      #2;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae got=%b exp=1", almost_empty); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_af got=%b exp=0", almost_full); end
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_dout got=%h exp=00", data_out); end
`ifdef SYNC_FIFO_V2_ERR_EN
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL rst_err got=%b exp=00", {overflow, underflow}); end
`endif
      tick();
      rst = 1'b0;
   endtask

   task automatic test_fill();
      wen = 1'b1; data_in = 8'hA1;
      tick();
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL fill1_count got=%0d exp=1", count); end
      checks++; if (data_out !== 8'hA1) begin errors++; $display("FAIL fill1_dout got=%h exp=a1", data_out); end
      checks++; if ({empty, almost_empty, almost_full, full} !== 4'b0100) begin errors++; $display("FAIL fill1_flags got=%b exp=0100", {empty, almost_empty, almost_full, full}); end
      data_in = 8'hB2;
      tick();
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL fill2_count got=%0d exp=2", count); end
      checks++; if ({empty, almost_empty, almost_full, full} !== 4'b0010) begin errors++; $display("FAIL fill2_flags got=%b exp=0010", {empty, almost_empty, almost_full, full}); end
      checks++; if (data_out !== 8'hA1) begin errors++; $display("FAIL fill2_dout got=%h exp=a1", data_out); end
      data_in = 8'hC3;
      tick();
      wen = 1'b0;
      checks++; if (count !== 2'd3) begin errors++; $display("FAIL fill3_count got=%0d exp=3", count); end
      checks++; if ({empty, almost_empty, almost_full, full} !== 4'b0011) begin errors++; $display("FAIL fill3_flags got=%b exp=0011", {empty, almost_empty, almost_full, full}); end
   endtask

   task automatic test_full_rw();
      logic [7:0] exp_q [3];
      exp_q[0] = 8'hB2; exp_q[1] = 8'hC3; exp_q[2] = 8'hD4;
      wen = 1'b1; ren = 1'b1; data_in = 8'hD4;
      tick();
      wen = 1'b0; ren = 1'b0;
      checks++; if (count !== 2'd3) begin errors++; $display("FAIL fullrw_count got=%0d exp=3", count); end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fullrw_full got=%b exp=1", full); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (data_out !== exp_q[i]) begin errors++; $display("FAIL fullrw_pop%0d got=%h exp=%h", i, data_out, exp_q[i]); end
         ren = 1'b1;
         tick();
         ren = 1'b0;
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullrw_empty got=%b exp=1", empty); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL fullrw_dout0 got=%h exp=00", data_out); end
   endtask

   task automatic test_empty_rw();
      wen = 1'b1; ren = 1'b1; data_in = 8'h5A;
      tick();
      wen = 1'b0; ren = 1'b0;
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL emptyrw_count got=%0d exp=1", count); end
      checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL emptyrw_dout got=%h exp=5a", data_out); end
`ifdef SYNC_FIFO_V2_ERR_EN
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL emptyrw_unf got=%b exp=0", underflow); end
`endif
      ren = 1'b1;
      tick();
      ren = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL emptyrw_drain got=%b exp=1", empty); end
   endtask

   task automatic test_wrap();
      logic [7:0] wv [7];
      wv[0] = 8'h10; wv[1] = 8'h21; wv[2] = 8'h32; wv[3] = 8'h43;
      wv[4] = 8'h54; wv[5] = 8'h65; wv[6] = 8'h76;
      wen = 1'b1; data_in = wv[0];
      tick();
      data_in = wv[1];
      tick();
      ren = 1'b1;
      for (int i = 2; i < 7; i++) begin
         data_in = wv[i];
         tick();
         checks++; if (data_out !== wv[i-1]) begin errors++; $display("FAIL wrap_dout%0d got=%h exp=%h", i, data_out, wv[i-1]); end
         checks++; if (count !== 2'd2) begin errors++; $display("FAIL wrap_count%0d got=%0d exp=2", i, count); end
      end
      wen = 1'b0;
      tick();
      checks++; if (data_out !== wv[6]) begin errors++; $display("FAIL wrap_tail got=%h exp=%h", data_out, wv[6]); end
      tick();
      ren = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
   endtask

   task automatic test_overflow_underflow();
      logic [7:0] ev [3];
      ev[0] = 8'hE1; ev[1] = 8'hE2; ev[2] = 8'hE3;
      wen = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_in = ev[i];
         tick();
      end
      data_in = 8'hFF;
      tick();
      wen = 1'b0;
      checks++; if (count !== 2'd3) begin errors++; $display("FAIL ovf_count got=%0d exp=3", count); end
`ifdef SYNC_FIFO_V2_ERR_EN
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
`endif
      for (int i = 0; i < 3; i++) begin
         checks++; if (data_out !== ev[i]) begin errors++; $display("FAIL ovf_intact%0d got=%h exp=%h", i, data_out, ev[i]); end
         ren = 1'b1;
         tick();
         ren = 1'b0;
      end
      ren = 1'b1;
      tick();
      ren = 1'b0;
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL unf_count got=%0d exp=0", count); end
`ifdef SYNC_FIFO_V2_ERR_EN
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", underflow); end
      ren = 1'b1; err_clr = 1'b1;
      tick();
      ren = 1'b0;
      checks++; if ({overflow, underflow} !== 2'b01) begin errors++; $display("FAIL clr_setwins got=%b exp=01", {overflow, underflow}); end
      tick();
      err_clr = 1'b0;
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clr_both got=%b exp=00", {overflow, underflow}); end
`endif
   endtask

   task automatic test_reset_mid();
      wen = 1'b1; data_in = 8'h3C;
      tick();
      data_in = 8'h4D;
      tick();
      wen = 1'b0;
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL mid_pre_count got=%0d exp=2", count); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", empty); end
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_dout got=%h exp=00", data_out); end
      tick();
      @(negedge clk);
      rst = 1'b0;
      wen = 1'b1; data_in = 8'h11;
      tick();
      wen = 1'b0;
      checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL mid_post_dout got=%h exp=11", data_out); end
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL mid_post_count got=%0d exp=1", count); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_fill();
      test_full_rw();
      test_empty_rw();
      test_wrap();
      test_overflow_underflow();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
